// File: rtl/truth_table_sweeper_if.sv
// Host-side bundle of the truth-table sweeper: start/abort control in,
// sweep status and captured results out.
interface truth_table_sweeper_if #(
    parameter int N_IN = 4
);
    logic                 start;
    logic                 abort;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [N_IN:0]        err_count;
    logic [N_IN-1:0]      first_fail_idx;
    logic                 first_fail_valid;
    logic [2**N_IN-1:0]   captured_tt;

    modport master (
        output start, abort,
        input  busy, done, pass, err_count, first_fail_idx, first_fail_valid, captured_tt
    );

    modport slave (
        input  start, abort,
        output busy, done, pass, err_count, first_fail_idx, first_fail_valid, captured_tt
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus sequencer for a combinational lab DUT: walks every input
// code, samples the DUT output after SETTLE cycles and scores it against EXP_TT.
module truth_table_sweeper #(
    parameter int                N_IN   = 4,
    parameter int                SETTLE = 2,
    parameter logic [2**N_IN-1:0] EXP_TT = 16'hF888
) (
    input  logic                     clk,
    input  logic                     rst_n,
    truth_table_sweeper_if.slave     host,
    input  logic                     dut_out,
    output logic [N_IN-1:0]          dut_in
);
    localparam int              SW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int              NCODES  = 2**N_IN;
    localparam logic [N_IN-1:0] IDX_MAX = N_IN'(NCODES - 1);
    localparam logic [SW-1:0]   SET_LST = SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [N_IN-1:0]    idx_r, idx_s;
    logic [SW-1:0]      settle_r, settle_s;
    logic [N_IN:0]      err_r, err_s;
    logic [N_IN-1:0]    ffi_r, ffi_s;
    logic               ffv_r, ffv_s;
    logic [NCODES-1:0]  tt_r, tt_s;
    logic               pass_r, pass_s;
    logic               busy_r, done_r;

    // Next-state and result bookkeeping for the sweep sequencer.
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        settle_s = settle_r;
        err_s    = err_r;
        ffi_s    = ffi_r;
        ffv_s    = ffv_r;
        tt_s     = tt_r;
        pass_s   = pass_r;
        case (state_r)
            ST_IDLE: begin
                if (host.start && !host.abort) begin
                    state_s  = ST_DRIVE;
                    idx_s    = {N_IN{1'b0}};
                    settle_s = {SW{1'b0}};
                    err_s    = {(N_IN+1){1'b0}};
                    ffv_s    = 1'b0;
                    tt_s     = {NCODES{1'b0}};
                    pass_s   = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (host.abort) begin
                    state_s  = ST_IDLE;
                    settle_s = {SW{1'b0}};
                    pass_s   = 1'b0;
                end else if (settle_r == SET_LST) begin
                    // Code has settled: score it, then advance or finish.
                    tt_s[idx_r] = dut_out;
                    if (dut_out != EXP_TT[idx_r]) begin
                        err_s = err_r + (N_IN+1)'(1);
                        if (!ffv_r) begin
                            ffi_s = idx_r;
                            ffv_s = 1'b1;
                        end else begin
                            ffi_s = ffi_r;
                        end
                    end else begin
                        err_s = err_r;
                    end
                    settle_s = {SW{1'b0}};
                    if (idx_r == IDX_MAX) begin
                        state_s = ST_DONE;
                        pass_s  = (err_s == {(N_IN+1){1'b0}});
                    end else begin
                        idx_s = idx_r + N_IN'(1);
                    end
                end else begin
                    settle_s = settle_r + SW'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                if (host.abort) begin
                    pass_s = 1'b0;
                end else begin
                    pass_s = pass_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and result registers; status outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            idx_r    <= {N_IN{1'b0}};
            settle_r <= {SW{1'b0}};
            err_r    <= {(N_IN+1){1'b0}};
            ffi_r    <= {N_IN{1'b0}};
            ffv_r    <= 1'b0;
            tt_r     <= {NCODES{1'b0}};
            pass_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            idx_r    <= idx_s;
            settle_r <= settle_s;
            err_r    <= err_s;
            ffi_r    <= ffi_s;
            ffv_r    <= ffv_s;
            tt_r     <= tt_s;
            pass_r   <= pass_s;
            busy_r   <= (state_s == ST_DRIVE);
            done_r   <= (state_s == ST_DONE);
        end
    end

    assign dut_in                = idx_r;
    assign host.busy             = busy_r;
    assign host.done             = done_r;
    assign host.pass             = pass_r;
    assign host.err_count        = err_r;
    assign host.first_fail_idx   = ffi_r;
    assign host.first_fail_valid = ffv_r;
    assign host.captured_tt      = tt_r;
endmodule
